// File: rtl/bitwise_logic_fifo.sv
// Registered AND/OR/XOR/NAND unit with a DEPTH-entry result FIFO and valid/ready handshakes.
// Optional macro BITWISE_LOGIC_FIFO_PARITY_EN adds a per-entry stored parity output y_parity.
module bitwise_logic_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         y,
`ifdef BITWISE_LOGIC_FIFO_PARITY_EN
  output logic                     y_parity,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef BITWISE_LOGIC_FIFO_PARITY_EN
  localparam int unsigned ENT_W = WIDTH + 1;
`else
  localparam int unsigned ENT_W = WIDTH;
`endif

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [ENT_W-1:0] head, head_nxt, wdata_c;
  logic [WIDTH-1:0] result_c;
  logic             push_c, pop_c;

  // Operation decode; NAND stays WIDTH bits wide by construction.
  always_comb begin
    result_c = '0;
    case (op)
      2'b00:   result_c = a & b;
      2'b01:   result_c = a | b;
      2'b10:   result_c = a ^ b;
      default: result_c = ~(a & b);
    endcase
  end

`ifdef BITWISE_LOGIC_FIFO_PARITY_EN
  assign wdata_c = {^result_c, result_c};
`else
  assign wdata_c = result_c;
`endif

  assign push_c = in_valid && in_ready;
  assign pop_c  = out_valid && out_ready;

  // Next pointers, occupancy and the head entry presented after this edge.
  always_comb begin
    wr_ptr_nxt = wr_ptr + PTR_W'(push_c);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop_c);
    count_nxt  = count;
    head_nxt   = '0;
    if (push_c && !pop_c) count_nxt = count + CNT_W'(1);
    else if (!push_c && pop_c) count_nxt = count - CNT_W'(1);
    // A push lands on the new head only when it is the sole surviving entry.
    if (count_nxt != '0) begin
      if (push_c && (wr_ptr == rd_ptr_nxt)) head_nxt = wdata_c;
      else head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      head      <= head_nxt;
      out_valid <= (count_nxt != '0);
      in_ready  <= (count_nxt < CNT_W'(DEPTH));
    end
  end

  // Payload storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wdata_c;
  end

  assign y = head[WIDTH-1:0];
`ifdef BITWISE_LOGIC_FIFO_PARITY_EN
  assign y_parity = head[WIDTH];
`endif

endmodule

// File: tb/tb_bitwise_logic_fifo.sv
// Self-checking bench for bitwise_logic_fifo against a queue-based reference model.
// Covers reset, each opcode, full stall, streaming wrap, random traffic and optional parity.
module tb_bitwise_logic_fifo;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a, b, y;
  logic [2:0]       count;
`ifdef BITWISE_LOGIC_FIFO_PARITY_EN
  logic             y_parity;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q [$];

  bitwise_logic_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y),
`ifdef BITWISE_LOGIC_FIFO_PARITY_EN
    .y_parity(y_parity),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] f(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
    int unsigned mask, xi, zi, r;
    mask = (1 << WIDTH) - 1;
    xi = x; zi = z;
    case (o)
      2'd0: r = xi & zi;
      2'd1: r = xi | zi;
      2'd2: r = xi ^ zi;
      default: r = mask - (xi & zi);
    endcase
    return WIDTH'(r);
  endfunction

  function automatic logic [WIDTH-1:0] exp_head();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  // Advance one clock edge, updating the reference model with what the edge should do.
  task automatic cycle();
    bit push_m, pop_m;
    logic [WIDTH-1:0] r;
    push_m = in_valid && (q.size() < DEPTH);
    pop_m  = out_ready && (q.size() != 0);
    r = f(op, a, b);
    @(posedge clk);
    if (pop_m) void'(q.pop_front());
    if (push_m) q.push_back(r);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; out_ready = 0; op = 0; a = 0; b = 0;
    #2;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || y !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_initial: count=%0d out_valid=%b y=%h in_ready=%b, want 0 0 0 1", count, out_valid, y, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    // Store three entries, then reset asynchronously between edges.
    in_valid = 1; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      op = 2'($urandom_range(0, 3)); a = 4'($urandom); b = 4'($urandom);
      cycle();
    end
    in_valid = 0;
    checks++;
    if (count !== 3'(q.size())) begin
      errors++;
      $display("FAIL reset_prefill: count=%0d want %0d", count, q.size());
    end
    rst = 1'b1;
    #1;
    q.delete();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || y !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: count=%0d out_valid=%b y=%h in_ready=%b, want 0 0 0 1", count, out_valid, y, in_ready);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic_and();
    in_valid = 1; op = 2'b00; a = 4'b0100; b = 4'b1100; out_ready = 1;
    cycle();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || y !== 4'b0100 || y !== exp_head()) begin
      errors++;
      $display("FAIL basic_and_out: out_valid=%b y=%b want 1 0100", out_valid, y);
    end
    cycle();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || y !== 4'd0) begin
      errors++;
      $display("FAIL basic_and_pop: count=%0d out_valid=%b y=%b want 0 0 0000", count, out_valid, y);
    end
    out_ready = 0;
  endtask

  task automatic test_all_ops();
    logic [WIDTH-1:0] want [4];
    want[0] = 4'b0010; want[1] = 4'b1110; want[2] = 4'b1100; want[3] = 4'b1101;
    out_ready = 0; in_valid = 1; a = 4'b1010; b = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      op = 2'(i);
      cycle();
    end
    in_valid = 0;
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL all_ops_full: count=%0d in_ready=%b out_valid=%b want 4 0 1", count, in_ready, out_valid);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (y !== want[i] || y !== exp_head()) begin
        errors++;
        $display("FAIL all_ops_drain%0d: y=%b want %b", i, y, want[i]);
      end
      cycle();
    end
    out_ready = 0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL all_ops_empty: count=%0d out_valid=%b want 0 0", count, out_valid);
    end
  endtask

  task automatic test_full_stall();
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      op = 2'($urandom_range(0, 3)); a = 4'($urandom); b = 4'($urandom);
      cycle();
    end
    op = 2'b00; a = 4'hF; b = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (count !== 3'd4 || in_ready !== 1'b0 || y !== exp_head()) begin
        errors++;
        $display("FAIL full_stall%0d: count=%0d in_ready=%b y=%h want 4 0 %h", i, count, in_ready, y, exp_head());
      end
    end
    out_ready = 1;
    cycle();
    out_ready = 0;
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: count=%0d in_ready=%b want 3 1", count, in_ready);
    end
    cycle();
    in_valid = 0;
    checks++;
    if (count !== 3'd4 || q[3] !== 4'hF) begin
      errors++;
      $display("FAIL full_accept: count=%0d want 4", count);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (y !== exp_head() || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_drain%0d: y=%h out_valid=%b want %h 1", i, y, out_valid, exp_head());
      end
      cycle();
    end
    out_ready = 0;
  endtask

  task automatic test_stream_wrap();
    in_valid = 1; out_ready = 1; op = 2'b10; b = 4'h5;
    for (int i = 0; i < 10; i++) begin
      a = 4'(i);
      cycle();
      checks++;
      if (count !== 3'd1 || out_valid !== 1'b1 || y !== (4'(i) ^ 4'h5) || y !== exp_head()) begin
        errors++;
        $display("FAIL stream%0d: count=%0d y=%h want 1 %h", i, count, y, 4'(i) ^ 4'h5);
      end
    end
    in_valid = 0;
    cycle();
    out_ready = 0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || y !== 4'd0) begin
      errors++;
      $display("FAIL stream_end: count=%0d out_valid=%b y=%h want 0 0 0", count, out_valid, y);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      // Hold the pair while stalled, as the driver contract demands.
      if (!(in_valid && !in_ready)) begin
        in_valid = 1'($urandom);
        op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      if (i >= 150) out_ready = 1'($urandom);
      cycle();
      checks++;
      if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) ||
          in_ready !== (q.size() < DEPTH) || y !== exp_head()) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL random%0d: count=%0d y=%h ov=%b ir=%b want %0d %h", i, count, y, out_valid, in_ready, q.size(), exp_head());
      end
    end
    in_valid = 0; out_ready = 1;
    repeat (DEPTH) cycle();
    out_ready = 0;
  endtask

`ifdef BITWISE_LOGIC_FIFO_PARITY_EN
  task automatic test_parity();
    out_ready = 0; in_valid = 1;
    op = 2'b01; a = 4'b0001; b = 4'b0010; cycle();
    op = 2'b00; a = 4'b0111; b = 4'b0111; cycle();
    in_valid = 0;
    checks++;
    if (y !== 4'b0011 || y_parity !== 1'b0) begin
      errors++;
      $display("FAIL parity0: y=%b p=%b want 0011 0", y, y_parity);
    end
    out_ready = 1; cycle(); out_ready = 0;
    checks++;
    if (y !== 4'b0111 || y_parity !== 1'b1) begin
      errors++;
      $display("FAIL parity1: y=%b p=%b want 0111 1", y, y_parity);
    end
    out_ready = 1; cycle(); out_ready = 0;
    checks++;
    if (y_parity !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL parity_empty: p=%b out_valid=%b want 0 0", y_parity, out_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_and();
    test_all_ops();
    test_full_stall();
    test_stream_wrap();
    test_random();
`ifdef BITWISE_LOGIC_FIFO_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_fifo.md
Name: bitwise_logic_fifo

Overview:
- Parametrised, registered successor to the plain combinational 4-bit AND cell.
- Accepts operand pairs a/b and a 2-bit opcode through a valid/ready handshake, then computes AND/OR/XOR/NAND at WIDTH bits.
- Buffers results in a DEPTH-entry FIFO and returns them through a valid/ready handshake.
- Sits between a stimulus/driver interface and any consumer that can stall.

Parameters:
- WIDTH, 4, operand and result width in bits (>=1)
- DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair and opcode present
- in_ready  output  1  block can accept a pair this cycle
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  FIFO head holds a result
- out_ready  input  1  consumer takes the head this cycle
- y  output  WIDTH  result at FIFO head
- count  output  $clog2(DEPTH)+1  number of stored results

Behaviour:
- Reset is asynchronous and active-high; clk and rst are the only clock and reset.
- While rst is high, and immediately on its assertion (no clock edge needed):
  - write pointer, read pointer and count go to 0
  - out_valid=0, y=0, in_ready=1
  - any entries in flight are discarded
- After rst deasserts, operation resumes on the next rising clk edge.
- Push:
  - in_valid && in_ready at a rising edge.
  - The result f(op,a,b) is computed combinationally and written into the FIFO at that edge.
  - NAND = ~(a&b), masked to WIDTH.
- Pop:
  - out_valid && out_ready at a rising edge.
  - Advances the read pointer.
- Flags:
  - in_ready = (count < DEPTH); no combinational dependence on out_ready, so no pass-through when full.
  - out_valid = (count != 0).
  - y is the head entry, registered storage only. y is 0 when empty.
- Latency: a pair accepted at edge N appears on y/out_valid after edge N (cycle N+1) if the FIFO was empty. Otherwise it appears in order behind earlier results.
- Order is strict FIFO; results are never reordered or dropped.
- Simultaneous push and pop in the same edge: both occur and count is unchanged.
  - When full, no push is possible that cycle, since in_ready=0.
  - When empty, no pop is possible, since out_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- count increments on push-only, decrements on pop-only, and never exceeds DEPTH or goes below 0.
- Inputs a/b/op are don't-care when in_valid=0. in_valid with in_ready=0 has no effect; the driver must hold its data.
- y and out_valid hold stable while out_valid && !out_ready.
- No internal state machine beyond the pointers and count. States are empty (count=0), partial, and full (count=DEPTH); transitions follow the push/pop rules above.

Optional Feature:
- Macro: BITWISE_LOGIC_FIFO_PARITY_EN
- When defined:
  - Adds output y_parity (1 bit) = ^y for the head entry.
  - Parity is stored per entry at push time, so the FIFO stores WIDTH+1 bits.
  - y_parity is 0 on reset and when empty.
- When undefined:
  - Port y_parity does not exist.
  - Storage is WIDTH bits.
  - All other behaviour is identical.

Test Plan:
- Reset/idle: assert rst mid-run with 3 entries stored -> count=0, out_valid=0, y=0, in_ready=1 immediately, without a clk edge.
- Basic AND: push op=00, a=4'b0100, b=4'b1100 with out_ready=1 -> next cycle out_valid=1, y=4'b0100; popped, then count=0.
- All ops, WIDTH=4: push a=4'b1010, b=4'b0110 with op 00/01/10/11 back-to-back, out_ready=0 -> count=4, in_ready=0. Then drain in order: 0010, 1110, 1100, 1101.
- Full stall: with FIFO full, hold in_valid=1, a=4'hF, b=4'hF for 5 cycles -> no push, count stays 4. Assert out_ready for 1 cycle -> count=3, in_ready=1, and the held pair is accepted next edge.
- Simultaneous push/pop and wrap: stream 10 pairs with in_valid=1, out_ready=1 continuously (op=10, a=i, b=4'h5) -> count stays at 1 after the first push. Results i^5 arrive in order across pointer wraparound.
- Parity (macro on): push op=01, a=4'b0001, b=4'b0010 -> y=4'b0011, y_parity=0. Push op=00, a=4'b0111, b=4'b0111 -> y=4'b0111, y_parity=1.
